// File: rtl/uart_rx_sampler_pkg.sv
// Shared UART definitions: receiver FSM states, parity mode codes and the
// bit-timing formulas used by both the RX front end and the future TX block.
//
// Contents:
//   rx_state_e     receiver FSM state encoding
//   PARITY_*       parity mode codes for the PARITY parameter
//   clks_per_bit() system clocks per serial bit (integer divide)
//   mid_point()    counter value at the middle of a bit
//   majority3()    2-of-3 vote
package uart_rx_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int mid_point(input int cpb);
        return cpb / 2;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter with restart, shared by the UART RX and TX paths.
// Counts 0..CLKS_PER_BIT-1 while enabled and sits at 0 while disabled.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   enable      count while high, hold at 0 while low
//   restart     force the count back to 0 (start-edge alignment)
//   vote_early  count == MID-1  (first vote sample)
//   vote_mid    count == MID    (second vote sample)
//   vote_late   count == MID+1  (third sample and vote decision)
//   bit_end     count == CLKS_PER_BIT-1
module uart_baud_counter
    import uart_rx_sampler_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic vote_early,
    output logic vote_mid,
    output logic vote_late,
    output logic bit_end
);

    localparam int MID = mid_point(CLKS_PER_BIT);
    localparam int CW  = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !enable) begin
            cnt <= '0;
        end else if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign vote_early = enable && (cnt == CW'(MID - 1));
    assign vote_mid   = enable && (cnt == CW'(MID));
    assign vote_late  = enable && (cnt == CW'(MID + 1));
    assign bit_end    = enable && (cnt == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronises the serial line, detects start edges,
// majority-votes every bit at mid-bit, assembles DATA_BITS frames with
// optional parity and 1/2 stop bits and hands bytes out over valid/ready.
//
// Ports:
//   clk_25mhz    system clock
//   reset_n      asynchronous active-low reset
//   rx_data      serial line, idle high, asynchronous
//   rx_byte      received payload, stable while rx_valid
//   rx_valid     payload available
//   rx_ready     consumer accepts on rx_valid && rx_ready
//   sample_tick  1-cycle pulse per mid-bit vote decision
//   last_bits    voted-bit history, newest in [0]
//   frame_err    1-cycle pulse: stop bit voted 0
//   parity_err   1-cycle pulse: parity mismatch
//   overrun_err  1-cycle pulse: good frame arrived while rx_valid still held
module uart_rx_sampler
    import uart_rx_sampler_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PARITY_NONE,
    parameter int STOP_BITS = 1,
    parameter int HIST_BITS = 4
) (
    input  logic                 clk_25mhz,
    input  logic                 reset_n,
    input  logic                 rx_data,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 sample_tick,
    output logic [HIST_BITS-1:0] last_bits,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);

    rx_state_e            state, state_next;
    logic                 sync1, sync2, sync3;
    logic                 fall;
    logic                 smp_early, smp_mid;
    logic                 voted;
    logic                 vote_early, vote_mid, vote_late, bit_end;
    logic                 last_data, last_stop;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bad, stop_bad;

    // sync1/sync2 are the metastability pair; sync3 only delays sync2 for edge detect.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= rx_data;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign fall = sync3 & ~sync2;

    uart_baud_counter #(
        .CLKS_PER_BIT(CPB)
    ) u_baud (
        .clk        (clk_25mhz),
        .rst_n      (reset_n),
        .enable     (state != ST_IDLE),
        .restart    ((state == ST_IDLE) && fall),
        .vote_early (vote_early),
        .vote_mid   (vote_mid),
        .vote_late  (vote_late),
        .bit_end    (bit_end)
    );

    // The receiver leaves the stop bit at mid-bit, so a full bit boundary can
    // only be seen while a frame is in progress.
    a_bit_end_in_frame: assert property (
        @(posedge clk_25mhz) disable iff (!reset_n) bit_end |-> (state != ST_IDLE)
    );

    // The third sample is taken live from sync2 on the decision cycle.
    assign voted     = majority3(smp_early, smp_mid, sync2);
    assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
    assign last_stop = (state == ST_STOP) && vote_late && (bit_cnt == 4'(STOP_BITS - 1));

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // NOTE: next state is defaulted first so no path through the case leaves
    // it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (fall) state_next = ST_START;
            ST_START:  if (vote_late) state_next = voted ? ST_IDLE : ST_DATA;
            ST_DATA:   if (vote_late && last_data)
                           state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (vote_late) state_next = ST_STOP;
            ST_STOP:   if (last_stop) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Frame assembly: vote samples, data shift register, parity and stop status.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            smp_early  <= 1'b1;
            smp_mid    <= 1'b1;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bad <= 1'b0;
            stop_bad   <= 1'b0;
        end else begin
            if (vote_early) smp_early <= sync2;
            if (vote_mid)   smp_mid   <= sync2;
            if (state == ST_IDLE) begin
                bit_cnt    <= '0;
                parity_bad <= 1'b0;
                stop_bad   <= 1'b0;
            end else if (vote_late) begin
                unique case (state)
                    ST_DATA: begin
                        // LSB arrives first, so shift right from the top.
                        shift_reg <= {voted, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= last_data ? 4'd0 : bit_cnt + 4'd1;
                    end
                    ST_PARITY: parity_bad <= ((^shift_reg) ^ voted) != (PARITY == PARITY_ODD);
                    ST_STOP: begin
                        stop_bad <= stop_bad | ~voted;
                        bit_cnt  <= bit_cnt + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output side: debug history, pulses and the valid/ready holding register.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            sample_tick <= 1'b0;
            last_bits   <= '1;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            rx_byte     <= '0;
            rx_valid    <= 1'b0;
        end else begin
            sample_tick <= vote_late;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            if (vote_late) begin
                for (int i = HIST_BITS - 1; i > 0; i--) last_bits[i] <= last_bits[i-1];
                last_bits[0] <= voted;
            end
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (last_stop) begin
                if (stop_bad | ~voted) begin
                    frame_err <= 1'b1;
                end else if (parity_bad) begin
                    parity_err <= 1'b1;
                end else if (rx_valid && !rx_ready) begin
                    overrun_err <= 1'b1;
                end else begin
                    // A same-cycle handshake frees the register, so the new
                    // byte replaces the old one and rx_valid stays high.
                    rx_byte  <= shift_reg;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule
